keypad_access_ctrl: RTL

Code-entry controller between the keypad scanner/decoder and the door lock driver. It collects decoded key strobes, compares the entered digits against a stored PIN, and drives `lock_req`, which feeds the lock driver's push-button/state input (1 = locked, 0 = released). The release window is timed. After repeated failures the block enters a timed lockout.

---
 rtl/keypad_access_ctrl_if.sv | 23 ++
 rtl/keypad_access_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/keypad_access_ctrl_if.sv
// Keypad-to-lock bundle: key strobes in, lock request and status out.
// The master side drives keys; the slave side is the access controller.
interface keypad_access_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       lock_req;
  logic       unlocked;
  logic       lockout;
  logic [3:0] digit_count;
  logic [3:0] fail_count;

  modport master (
    output key_valid, key_code,
    input  lock_req, unlocked, lockout,
    input  digit_count, fail_count
  );

  modport slave (
    input  key_valid, key_code,
    output lock_req, unlocked, lockout,
    output digit_count, fail_count
  );
endinterface

// File: rtl/keypad_access_ctrl.sv
// PIN-entry controller: collects BCD digits, checks them against PIN,
// opens the lock for a timed window and locks out after repeated failures.
module keypad_access_ctrl #(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] PIN  = 16'h1234,
  parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 250_000_000
) (
  input logic                clk,
  input logic                reset,
  keypad_access_ctrl_if.slave bus
);

  localparam int unsigned BW   = 4 * CODE_LEN;
  localparam int unsigned TMAX =
    (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [3:0]  CL   = 4'(CODE_LEN);
  localparam logic [3:0]  MF   = 4'(MAX_FAILS);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic [3:0]      fail_q, fail_d;
  logic            ovf_q, ovf_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            lock_q, unl_q, lo_q;

  logic is_dig, is_clr, is_ent, match;

  assign is_dig = bus.key_valid && (bus.key_code <= 4'd9);
  assign is_clr = bus.key_valid && (bus.key_code == 4'hA);
  assign is_ent = bus.key_valid && (bus.key_code == 4'hB);
  assign match  = (dcnt_q == CL) && !ovf_q && (buf_q == PIN);

  // Next-state and datapath decisions for entry, check, window and lockout
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    dcnt_d  = dcnt_q;
    fail_d  = fail_q;
    ovf_d   = ovf_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          is_dig: begin
            if (dcnt_q < CL) begin
              buf_d  = (buf_q << 4) | BW'(bus.key_code);
              dcnt_d = dcnt_q + 4'd1;
            end else begin
              ovf_d  = 1'b1;
            end
          end
          is_clr: begin
            buf_d  = '0;
            dcnt_d = '0;
            ovf_d  = 1'b0;
          end
          is_ent:  state_d = CHECK;
          default: ;
        endcase
      end
      CHECK: begin
        buf_d  = '0;
        dcnt_d = '0;
        ovf_d  = 1'b0;
        if (match) begin
          state_d = UNLOCKED;
          fail_d  = '0;
          tmr_d   = TW'(UNLOCK_CYCLES - 1);
        end else if (fail_q + 4'd1 < MF) begin
          state_d = IDLE;
          fail_d  = fail_q + 4'd1;
        end else begin
          state_d = LOCKOUT;
          fail_d  = MF;
          tmr_d   = TW'(LOCKOUT_CYCLES - 1);
        end
      end
      UNLOCKED: begin
        if (is_ent || tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; status outputs are decoded from the next state
  // so they change on the same edge as the state itself
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      dcnt_q  <= '0;
      fail_q  <= '0;
      ovf_q   <= 1'b0;
      tmr_q   <= '0;
      lock_q  <= 1'b1;
      unl_q   <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dcnt_q  <= dcnt_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
      tmr_q   <= tmr_d;
      lock_q  <= (state_d != UNLOCKED);
      unl_q   <= (state_d == UNLOCKED);
      lo_q    <= (state_d == LOCKOUT);
    end
  end

  assign bus.lock_req    = lock_q;
  assign bus.unlocked    = unl_q;
  assign bus.lockout     = lo_q;
  assign bus.digit_count = dcnt_q;
  assign bus.fail_count  = fail_q;

endmodule
